// File: rtl/dec_pulse.sv
// dec_pulse: accepts a 3-bit code and plays it out as a one-hot pulse that is
// held for HOLD cycles, followed by GAP all-zero cycles. While a pulse is
// playing, one further code can wait in a single-entry pending slot.
//
// state | meaning
// IDLE  | no pulse playing, pending slot empty
// DRIVE | out holds the one-hot of the active code
// GAP   | out is zero between a pulse and whatever follows it
//
// If a code is accepted on the final edge of a period and nothing is
// pending, it starts driving directly rather than being parked. Parking it
// would leave the block in IDLE with a full slot and nothing to drain it.
module dec_pulse #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy,
  output logic [7:0] pulse_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

  state_t     state_q, state_d;
  logic [7:0] out_q, out_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] pend_code_q, pend_code_d;
  logic       pend_full_q, pend_full_d;
  logic [7:0] pulse_cnt_q, pulse_cnt_d;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       accept;

  assign accept    = in_valid & in_ready_q & en;
  assign in_ready  = in_ready_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign pulse_cnt = pulse_cnt_q;

  // Next-state decode: sequencing through DRIVE/GAP and managing the pending slot.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    pend_code_d = pend_code_q;
    pend_full_d = pend_full_q;
    pulse_cnt_d = pulse_cnt_q;
    if (!en) begin
      state_d     = S_IDLE;
      out_d       = 8'h00;
      cnt_d       = 8'h00;
      pend_code_d = 3'd0;
      pend_full_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = S_DRIVE;
            out_d   = 8'h01 << in;
            cnt_d   = HOLD_M1;
          end
        end
        S_DRIVE: begin
          if (cnt_q != 8'h00) begin
            cnt_d = cnt_q - 8'h01;
            if (accept) begin
              pend_code_d = in;
              pend_full_d = 1'b1;
            end
          end else begin
            pulse_cnt_d = pulse_cnt_q + 8'h01;
            if (GAP > 0) begin
              state_d = S_GAP;
              out_d   = 8'h00;
              cnt_d   = GAP_M1;
              if (accept) begin
                pend_code_d = in;
                pend_full_d = 1'b1;
              end
            end else if (pend_full_q) begin
              out_d       = 8'h01 << pend_code_q;
              cnt_d       = HOLD_M1;
              pend_full_d = 1'b0;
            end else if (accept) begin
              out_d = 8'h01 << in;
              cnt_d = HOLD_M1;
            end else begin
              state_d = S_IDLE;
              out_d   = 8'h00;
            end
          end
        end
        S_GAP: begin
          if (cnt_q != 8'h00) begin
            cnt_d = cnt_q - 8'h01;
            if (accept) begin
              pend_code_d = in;
              pend_full_d = 1'b1;
            end
          end else if (pend_full_q) begin
            state_d     = S_DRIVE;
            out_d       = 8'h01 << pend_code_q;
            cnt_d       = HOLD_M1;
            pend_full_d = 1'b0;
          end else if (accept) begin
            state_d = S_DRIVE;
            out_d   = 8'h01 << in;
            cnt_d   = HOLD_M1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 8'h00;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_d       = 8'h00;
          cnt_d       = 8'h00;
          pend_full_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset wins over enable and any accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_q       <= 8'h00;
      cnt_q       <= 8'h00;
      pend_code_q <= 3'd0;
      pend_full_q <= 1'b0;
      pulse_cnt_q <= 8'h00;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      pend_code_q <= pend_code_d;
      pend_full_q <= pend_full_d;
      pulse_cnt_q <= pulse_cnt_d;
      in_ready_q  <= en & ~pend_full_d;
      out_valid_q <= (out_d != 8'h00);
      busy_q      <= (state_d != S_IDLE) | pend_full_d;
    end
  end

endmodule

// File: tb/tb_dec_pulse.sv
// Bench for dec_pulse: two instances (GAP=1 and GAP=0, HOLD=4) share stimulus.
// A timeline model (active code, cycles since pulse start, pending code)
// predicts every output every cycle; directed scenarios add literal checks.
module tb_dec_pulse;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst, en, in_valid;
  logic [2:0] din;
  logic       rdy0, rdy1, ov0, ov1, bz0, bz1;
  logic [7:0] out0, out1, pc0, pc1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dec_pulse #(.HOLD(4), .GAP(1)) u_g1 (
    .clk(clk), .rst(rst), .en(en), .in(din), .in_valid(in_valid),
    .in_ready(rdy0), .out(out0), .out_valid(ov0), .busy(bz0), .pulse_cnt(pc0));

  dec_pulse #(.HOLD(4), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .en(en), .in(din), .in_valid(in_valid),
    .in_ready(rdy1), .out(out1), .out_valid(ov1), .busy(bz1), .pulse_cnt(pc1));

  // model: per instance, active code (-1 none), cycles since its pulse began,
  // pending code (-1 empty), completed-pulse count and ready flag
  int gap_of [2] = '{1, 0};
  int m_cur  [2] = '{-1, -1};
  int m_t    [2] = '{0, 0};
  int m_pend [2] = '{-1, -1};
  int m_cnt  [2] = '{0, 0};
  bit m_rdy  [2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_step(int k);
    bit acc;
    int g;
    g = gap_of[k];
    if (rst) begin
      m_cur[k] = -1; m_t[k] = 0; m_pend[k] = -1; m_cnt[k] = 0; m_rdy[k] = 0;
      return;
    end
    if (!en) begin
      m_cur[k] = -1; m_t[k] = 0; m_pend[k] = -1; m_rdy[k] = 0;
      return;
    end
    acc = in_valid && m_rdy[k];
    if (m_cur[k] < 0) begin
      if (acc) begin m_cur[k] = int'(din); m_t[k] = 0; end
    end else begin
      m_t[k]++;
      if (m_t[k] == HOLD) m_cnt[k] = (m_cnt[k] + 1) % 256;
      if (m_t[k] == HOLD + g) begin
        if (m_pend[k] >= 0) begin
          m_cur[k] = m_pend[k]; m_pend[k] = -1; m_t[k] = 0;
        end else if (acc) begin
          m_cur[k] = int'(din); m_t[k] = 0; acc = 0;
        end else begin
          m_cur[k] = -1;
        end
      end
      if (acc) m_pend[k] = int'(din);
    end
    m_rdy[k] = (m_pend[k] < 0);
  endfunction

  function automatic logic [7:0] exp_out(int k);
    if (m_cur[k] >= 0 && m_t[k] < HOLD) return 8'(1 << m_cur[k]);
    return 8'h00;
  endfunction

  task automatic compare_dut(int k);
    logic [7:0] a_out, a_pc, e_out;
    logic a_ov, a_bz, a_rdy;
    a_out = (k == 0) ? out0 : out1;
    a_pc  = (k == 0) ? pc0  : pc1;
    a_ov  = (k == 0) ? ov0  : ov1;
    a_bz  = (k == 0) ? bz0  : bz1;
    a_rdy = (k == 0) ? rdy0 : rdy1;
    e_out = exp_out(k);
    check($sformatf("model_out[%0d]", k), 32'(a_out), 32'(e_out));
    check($sformatf("model_out_valid[%0d]", k), 32'(a_ov), 32'(e_out != 8'h00));
    check($sformatf("model_busy[%0d]", k), 32'(a_bz), 32'(m_cur[k] >= 0 || m_pend[k] >= 0));
    check($sformatf("model_pulse_cnt[%0d]", k), 32'(a_pc), 32'(m_cnt[k]));
    check($sformatf("model_in_ready[%0d]", k), 32'(a_rdy), 32'(m_rdy[k]));
  endtask

  // advance the model with the inputs present at this edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // compare both instances just after every edge
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) compare_dut(k);
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bz0 || bz1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(bz0 | bz1), 32'd0);
  endtask

  task automatic offer(input logic [2:0] c);
    int n;
    n = 0;
    while (!rdy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(rdy0), 32'd1);
    din = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [7:0] tbl_oh [8]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] exp35  [9]  = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h20, 8'h20, 8'h20, 8'h20};
  logic [7:0] exp36  [9]  = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00};

  initial begin
    int pc_exp;
    int hits;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; din = 3'd0;

    // reset behaviour and release
    @(negedge clk);
    check("rst_out", 32'(out0), 32'h0);
    check("rst_ov", 32'(ov0), 32'h0);
    check("rst_busy", 32'(bz0), 32'h0);
    check("rst_pc", 32'(pc0), 32'h0);
    check("rst_ready", 32'(rdy0), 32'h0);
    en = 1'b1;
    @(negedge clk);
    check("rst_over_en_ready", 32'(rdy0), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", 32'(rdy0), 32'h1);

    // codes 0..7, one at a time
    for (int c = 0; c < 8; c++) begin
      offer(3'(c));
      for (int i = 0; i < 4; i++) begin
        check($sformatf("seq_hold_c%0d_%0d", c, i), 32'(out0), 32'(tbl_oh[c]));
        @(negedge clk);
      end
      check($sformatf("seq_gap_c%0d", c), 32'(out0), 32'h0);
    end
    check("seq_pulse_cnt", 32'(pc0), 32'd8);
    wait_idle();

    // 3 accepted, 5 offered continuously and parked
    din = 3'd3; in_valid = 1'b1;
    @(negedge clk);
    din = 3'd5;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("pend_seq_%0d", i), 32'(out0), 32'(exp35[i]));
      if (i == 1) check("pend_ready_low", 32'(rdy0), 32'h0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle();

    // GAP=0 instance: back-to-back 6 then 1
    din = 3'd6; in_valid = 1'b1;
    @(negedge clk);
    din = 3'd1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("gap0_seq_%0d", i), 32'(out1), 32'(exp36[i]));
      @(negedge clk);
      if (i == 0) in_valid = 1'b0;
    end
    wait_idle();

    // en dropped in the 2nd DRIVE cycle with a pending code
    din = 3'd2; in_valid = 1'b1;
    @(negedge clk);
    din = 3'd7;
    @(negedge clk);
    pc_exp = m_cnt[0];
    in_valid = 1'b0; en = 1'b0;
    @(negedge clk);
    check("abort_out", 32'(out0), 32'h0);
    check("abort_ov", 32'(ov0), 32'h0);
    check("abort_busy", 32'(bz0), 32'h0);
    check("abort_ready", 32'(rdy0), 32'h0);
    check("abort_pc", 32'(pc0), 32'(pc_exp));
    en = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out0 == 8'h80) hits++;
    end
    check("abort_pending_never_out", 32'(hits), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      en       = ($urandom_range(0, 39) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      din      = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    rst = 1'b0; en = 1'b1; in_valid = 1'b0;
    wait_idle();

    // counter wrap
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 255; p++) offer(3'(p % 8));
    wait_idle();
    check("wrap_pc_255", 32'(pc0), 32'hFF);
    offer(3'd4);
    wait_idle();
    check("wrap_pc_0", 32'(pc0), 32'h00);
    offer(3'd4);
    wait_idle();
    check("pc_after_wrap", 32'(pc0), 32'h01);

    // reset mid-pulse
    offer(3'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out", 32'(out0), 32'h0);
    check("midrst_pc", 32'(pc0), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dec_pulse.md
DEC_PULSE -- requirements
Module: dec_pulse

Interface
REQ-001 Parameter HOLD, default 4, sets the number of clk cycles each one-hot output pulse is driven; legal range 1..255.
REQ-002 Parameter GAP, default 1, sets the number of all-zero clk cycles inserted after each pulse; legal range 0..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port en, input, 1 bit: block enable; low aborts activity.
REQ-006 Port in, input, 3 bits: binary code to decode.
REQ-007 Port in_valid, input, 1 bit: the value on in is offered.
REQ-008 Port in_ready, output, 1 bit: the block can accept a code.
REQ-009 Port out, output, 8 bits: one-hot decoded pulse, where bit N high means code N.
REQ-010 Port out_valid, output, 1 bit: high exactly while out is non-zero.
REQ-011 Port busy, output, 1 bit: high whenever the state is not IDLE or the pending slot is full.
REQ-012 Port pulse_cnt, output, 8 bits: count of completed pulses.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, DRIVE and GAP, plus a one-entry pending slot (3-bit code and a full flag).
REQ-014 Accept SHALL occur at a rising edge where in_valid, in_ready and en are all high.
REQ-015 in_ready SHALL be driven from registers only: en AND pending slot not full AND not rst.
REQ-016 IDLE accept: at the next edge the state SHALL be DRIVE and out SHALL equal 1 << in, giving 1-cycle latency; the pending slot stays unused.
REQ-017 An accept in DRIVE or GAP SHALL store the code into the pending slot and set the pending full flag.
REQ-018 DRIVE SHALL hold out stable for exactly HOLD cycles, using an 8-bit down-counter loaded with HOLD-1.
REQ-019 DRIVE end with GAP > 0: the state SHALL become GAP and out SHALL be 8'h00 for exactly GAP cycles.
REQ-020 DRIVE end with GAP = 0 and the pending slot full: the state SHALL stay DRIVE, out SHALL switch to the pending code's one-hot, and the pending slot SHALL clear.
REQ-021 DRIVE end with GAP = 0 and the pending slot empty: the state SHALL become IDLE.
REQ-022 GAP end with the pending slot full: the state SHALL become DRIVE using the pending code, and the pending slot SHALL clear.
REQ-023 GAP end with the pending slot empty: the state SHALL become IDLE.
REQ-024 The pending slot SHALL NOT be loaded and drained at the same edge, because in_ready is low while the slot is full.
REQ-025 pulse_cnt SHALL increment by 1 at the edge where a DRIVE period completes normally, wrapping from 255 to 0.
REQ-026 en low at an edge: the next state SHALL be IDLE, out = 0, out_valid = 0, the pending slot cleared, and pulse_cnt unchanged (an aborted pulse is not counted).
REQ-027 While en is low the block SHALL remain in IDLE with in_ready = 0.
REQ-028 out SHALL be at most one-hot in every cycle, and SHALL never be X or Z.

Reset
REQ-029 rst high at an edge SHALL force: state IDLE, out = 8'h00, out_valid = 0, busy = 0, pulse_cnt = 8'h00, pending slot cleared, counters 0.
REQ-030 in_ready SHALL be 0 while rst is high.
REQ-031 rst SHALL take priority over en and over any accept at the same edge.
REQ-032 rst asserted mid-DRIVE or mid-GAP SHALL abort the pulse without incrementing pulse_cnt.

Verification (HOLD = 4, GAP = 1 unless stated)
REQ-033 Scenario: rst for 2 cycles -> all outputs 0 and in_ready = 0; first edge after release with en = 1 -> in_ready = 1.
REQ-034 Scenario: codes 0..7 offered one at a time, each when in_ready is high -> out = 8'h01, 8'h02, ..., 8'h80, each for 4 cycles, each followed by 1 cycle of 8'h00; pulse_cnt = 8 at the end.
REQ-035 Scenario: in = 3 accepted, then in = 5 offered every cycle -> 5 is held in the pending slot and in_ready drops; out = 8'h08 for 4 cycles, then 8'h00 for 1 cycle, then 8'h20 for 4 cycles.
REQ-036 Scenario: GAP = 0, back-to-back codes 6 and 1 -> out = 8'h40 for 4 cycles immediately followed by 8'h02 for 4 cycles, with no zero cycle between them.
REQ-037 Scenario: en dropped at the 2nd cycle of DRIVE with a pending code present -> next cycle out = 0, busy = 0, pulse_cnt unchanged, and the pending code is never output.
REQ-038 Scenario: 256 completed pulses -> pulse_cnt wraps to 0; rst asserted mid-pulse -> pulse_cnt = 0 and out = 0 at the next edge.
